load_store_unit: RTL and testbench

- Bus master that sits directly upstream of the bus controller and drives its bus_master.out modport on behalf of the core's memory stage.
- Bus transfers are always 32-bit, so this block turns byte, halfword and word loads/stores into aligned word transfers.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: performs a read-modify-write.
- Misalignment and bus errors are reported back to the core.

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus master port bundle between the load/store unit and the bus controller.
// Latency: none (wiring only).
// Backpressure: the controller holds ready low to insert wait states while active.
//   out : start, write, address, write_data driven by the master;
//         read_data, response, ready, active returned by the controller.
//   in  : the same signals seen from the controller side.
interface bus_master;
    logic        start;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [1:0]  response;
    logic        ready;
    logic        active;

    modport out (
        output start, write, address, write_data,
        input  read_data, response, ready, active
    );

    modport in (
        input  start, write, address, write_data,
        output read_data, response, ready, active
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word core accesses into aligned 32-bit bus transfers.
// Latency: 3 cycles for loads and word stores, 6 for sub-word stores (zero-wait slave), 1 on alignment error.
// Backpressure: req_ready is high only in IDLE; one request in flight, bus wait states stall the FSM.
//   clk/rst        : clock, asynchronous active-low reset
//   req_*          : core request (valid/ready handshake), captured at acceptance
//   resp_*         : single-cycle completion pulse with extended load data and error flag
//   bus            : master side of the bus controller
module load_store_unit #(
    parameter bit RMW_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    bus_master.out      bus
);

    localparam logic [1:0] RESP_ERROR = 2'd1;
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_nxt;

    // Request fields held for the whole operation.
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;      // only the sub-word part is needed for the merge
    logic [31:0] rd_word_q;    // word fetched by the read phase of a read-modify-write

    // Response and bus output registers.
    logic [31:0] rdata_q;
    logic        error_q;
    logic        start_q;
    logic        bus_write_q;
    logic [31:0] address_q;
    logic [31:0] bus_wdata_q;

    logic        accept;
    logic        req_bad;
    logic        req_word_store;
    logic        xfer_done;
    logic        bus_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready  = (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign xfer_done  = bus.active && bus.ready;
    assign bus_err    = (bus.response == RESP_ERROR);

    assign req_word_store = req_write && (req_size == SZ_WORD);

    // Everything that can be rejected without touching the bus.
    assign req_bad = (req_size == 2'd3)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (!RMW_ENABLE && req_write && (req_size != SZ_WORD));

    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    assign bus.start      = start_q;
    assign bus.write      = bus_write_q;
    assign bus.address    = address_q;
    assign bus.write_data = bus_wdata_q;

    // Lane extraction from the live read data, used on the completing edge.
    always_comb begin
        byte_lane = bus.read_data[{addr_lo_q, 3'b000} +: 8];
        half_lane = bus.read_data[{addr_lo_q[1], 4'b0000} +: 16];
        load_ext  = bus.read_data;
        case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = unsigned_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = bus.read_data;
        endcase
    end

    // Insert the right-aligned store data into its lane of the fetched word.
    always_comb begin
        merged = rd_word_q;
        if (size_q == SZ_BYTE) begin
            merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad)             state_nxt = S_DONE;
                    else if (req_word_store) state_nxt = S_WR;
                    else                     state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (xfer_done) begin
                    if (bus_err)      state_nxt = S_DONE;
                    else if (write_q) state_nxt = S_MERGE;
                    else              state_nxt = S_DONE;
                end
            end
            S_MERGE: state_nxt = S_WR;
            S_WR: begin
                if (xfer_done) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            unsigned_q  <= 1'b0;
            addr_lo_q   <= 2'd0;
            wdata_q     <= 16'd0;
            rd_word_q   <= 32'd0;
            rdata_q     <= 32'd0;
            error_q     <= 1'b0;
            start_q     <= 1'b0;
            bus_write_q <= 1'b0;
            address_q   <= 32'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_lo_q  <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        rdata_q    <= 32'd0;
                        error_q    <= req_bad;
                        if (!req_bad) begin
                            start_q     <= 1'b1;
                            bus_write_q <= req_word_store;
                            address_q   <= {req_addr[31:2], 2'b00};
                            if (req_word_store) begin
                                bus_wdata_q <= req_wdata;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (xfer_done) begin
                        start_q <= 1'b0;
                        if (bus_err) begin
                            error_q <= 1'b1;
                        end else if (write_q) begin
                            rd_word_q <= bus.read_data;
                        end else begin
                            rdata_q <= load_ext;
                        end
                    end
                end
                S_MERGE: begin
                    start_q     <= 1'b1;
                    bus_write_q <= 1'b1;
                    bus_wdata_q <= merged;
                end
                S_WR: begin
                    if (xfer_done) begin
                        start_q     <= 1'b0;
                        bus_write_q <= 1'b0;
                        error_q     <= bus_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table plus reset sequences against a simple bus slave.
// Latency: slave raises active the cycle after it sees start, then ready after a set number of wait states.
// Backpressure: wait states are set per vector through slave_waits.
module tb_load_store_unit;

    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    bus_master bus_if();

    load_store_unit #(.RMW_ENABLE(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model
    logic [31:0] slave_word;
    logic        slave_err;
    int          slave_waits;
    logic        s_active;
    int          s_wcnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    int          rd_cnt;
    int          wr_cnt;
    int          start_cyc;
    logic [31:0] last_rd_addr;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    assign bus_if.read_data = slave_word;
    assign bus_if.response  = slave_err ? RESP_ERROR : RESP_OKAY;
    assign bus_if.active    = s_active;
    assign bus_if.ready     = s_active && (s_wcnt == 0);

    initial begin
        rd_cnt = 0; wr_cnt = 0; start_cyc = 0;
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
        lat_write = 1'b0; lat_addr = '0; lat_wdata = '0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_active <= 1'b0;
            s_wcnt   <= 0;
        end else if (s_active) begin
            if (s_wcnt == 0) begin
                s_active <= 1'b0;
                if (lat_write) begin
                    wr_cnt       <= wr_cnt + 1;
                    last_wr_addr <= lat_addr;
                    last_wr_data <= lat_wdata;
                end else begin
                    rd_cnt       <= rd_cnt + 1;
                    last_rd_addr <= lat_addr;
                end
            end else begin
                s_wcnt <= s_wcnt - 1;
            end
        end else if (bus_if.start) begin
            s_active  <= 1'b1;
            s_wcnt    <= slave_waits;
            lat_write <= bus_if.write;
            lat_addr  <= bus_if.address;
            lat_wdata <= bus_if.write_data;
        end
    end

    always @(posedge clk) begin
        if (bus_if.start) start_cyc <= start_cyc + 1;
    end

    int total;
    int bad;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request from IDLE; cyc = cycle of resp_valid (acceptance edge = 0), 0 on timeout.
    task automatic run_req(input string nm, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d,
                           output int cyc, output logic [31:0] rd, output logic er);
        logic found;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        cyc = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (!found) begin
                if (resp_valid) begin
                    found = 1'b1;
                    cyc = i;
                    rd  = resp_rdata;
                    er  = resp_error;
                    check({nm, " ready_low_in_resp"}, {31'd0, req_ready}, 32'd0);
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (found) begin
            @(posedge clk);
            #1;
            check({nm, " resp_single_pulse"}, {31'd0, resp_valid}, 32'd0);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        serr;
        int          waits;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        logic [31:0] bus_addr;
        logic [31:0] wr_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic        er;
        int          rd0, wr0, st0, quiet;
        string       nm;

        total = 0; bad = 0;
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        slave_word = '0; slave_err = 1'b0; slave_waits = 0;

        //           w     sz     u     addr          wdata         word          serr  wt cyc rdata         err  rd wr bus_addr      wr_data
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0, 32'h0000_0100, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 0, 3, 32'hFFFF_FF80, 1'b0, 1, 0, 32'h0000_0100, 32'h0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 0, 3, 32'h0000_0080, 1'b0, 1, 0, 32'h0000_0100, 32'h0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1'b0, 0, 3, 32'hFFFF_80FF, 1'b0, 1, 0, 32'h0000_0100, 32'h0};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0,        32'h1234_8001, 1'b0, 0, 3, 32'h0000_8001, 1'b0, 1, 0, 32'h0000_0000, 32'h0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        32'h80FF_1234, 1'b0, 0, 3, 32'h0000_0012, 1'b0, 1, 0, 32'h0000_0100, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0,        32'h00AB_0000, 1'b0, 0, 3, 32'h0000_00AB, 1'b0, 1, 0, 32'h0000_0100, 32'h0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1122_3344, 1'b0, 0, 6, 32'h0,         1'b0, 1, 1, 32'h0000_0200, 32'hABCD_3344};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'hFFFF_FF5A, 32'h1122_3344, 1'b0, 0, 6, 32'h0,         1'b0, 1, 1, 32'h0000_0010, 32'h1122_5A44};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         1'b0, 0, 3, 32'h0,         1'b0, 0, 1, 32'h0000_0020, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0,        32'h5555_5555, 1'b0, 0, 1, 32'h0,         1'b1, 0, 0, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'h1234_5678, 32'h0,         1'b0, 0, 1, 32'h0,         1'b1, 0, 0, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h5555_5555, 1'b0, 0, 1, 32'h0,         1'b1, 0, 0, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'h0000_0077, 32'h1122_3344, 1'b1, 0, 3, 32'h0,         1'b1, 1, 0, 32'h0000_0010, 32'h0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,        32'h0BAD_F00D, 1'b0, 3, 6, 32'h0BAD_F00D, 1'b0, 1, 0, 32'h0000_0040, 32'h0};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h0000_0048, 32'h0,        32'h7777_7777, 1'b1, 0, 3, 32'h0,         1'b1, 1, 0, 32'h0000_0048, 32'h0};
        vecs[16] = '{1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'h0102_0304, 32'h0,         1'b1, 0, 3, 32'h0,         1'b1, 0, 1, 32'h0000_0044, 32'h0102_0304};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready",  {31'd0, req_ready},       32'd1);
        check("rst resp_valid", {31'd0, resp_valid},      32'd0);
        check("rst resp_error", {31'd0, resp_error},      32'd0);
        check("rst resp_rdata", resp_rdata,               32'd0);
        check("rst start",      {31'd0, bus_if.start},    32'd0);
        check("rst write",      {31'd0, bus_if.write},    32'd0);
        check("rst address",    bus_if.address,           32'd0);
        check("rst write_data", bus_if.write_data,        32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            nm = $sformatf("vec%0d", i);
            slave_word  = vecs[i].word;
            slave_err   = vecs[i].serr;
            slave_waits = vecs[i].waits;
            rd0 = rd_cnt; wr0 = wr_cnt; st0 = start_cyc;
            run_req(nm, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wdata, cyc, rd, er);
            check({nm, " cycle"}, 32'(cyc), 32'(vecs[i].cyc));
            check({nm, " rdata"}, rd, vecs[i].rdata);
            check({nm, " error"}, {31'd0, er}, {31'd0, vecs[i].err});
            check({nm, " reads"}, 32'(rd_cnt - rd0), 32'(vecs[i].nrd));
            check({nm, " writes"}, 32'(wr_cnt - wr0), 32'(vecs[i].nwr));
            check({nm, " any_start"}, {31'd0, (start_cyc != st0)},
                  {31'd0, ((vecs[i].nrd + vecs[i].nwr) != 0)});
            if (vecs[i].nrd > 0) check({nm, " rd_addr"}, last_rd_addr, vecs[i].bus_addr);
            if (vecs[i].nwr > 0) begin
                check({nm, " wr_addr"}, last_wr_addr, vecs[i].bus_addr);
                check({nm, " wr_data"}, last_wr_data, vecs[i].wr_data);
            end
        end

        // Reset while the write phase is waiting on the slave
        slave_word = 32'h0; slave_err = 1'b0; slave_waits = 5;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0030; req_wdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("midwr start_before", {31'd0, bus_if.start}, 32'd1);
        check("midwr write_before", {31'd0, bus_if.write}, 32'd1);
        rst = 1'b0;
        #1;
        check("midwr start_now", {31'd0, bus_if.start}, 32'd0);
        check("midwr ready_now", {31'd0, req_ready},    32'd1);
        @(negedge clk);
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) quiet++;
        end
        check("midwr no_resp", 32'(quiet), 32'd0);

        slave_word = 32'h2468_ACE0; slave_waits = 0;
        wr0 = wr_cnt;
        run_req("after_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, cyc, rd, er);
        check("after_rst cycle",  32'(cyc), 32'd3);
        check("after_rst rdata",  rd, 32'h2468_ACE0);
        check("after_rst error",  {31'd0, er}, 32'd0);
        check("after_rst no_wr",  32'(wr_cnt - wr0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
